// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares the unified memory between fetch and load/store ports,
//            with range and alignment fault checking on every access.
//            Define MEM_ARB_RR_EN for round-robin arbitration; the default
//            build gives the data port fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int BUS_WIDTH = 32,
   parameter int MEM_DEPTH = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 if_req,
   input  logic [BUS_WIDTH-1:0] if_addr,
   output logic                 if_ack,
   output logic [BUS_WIDTH-1:0] if_rdata,
   output logic                 if_err,
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [BUS_WIDTH-1:0] d_addr,
   input  logic [BUS_WIDTH-1:0] d_wdata,
   input  logic [1:0]           d_size,
   input  logic                 d_sz_ex,
   output logic                 d_ack,
   output logic [BUS_WIDTH-1:0] d_rdata,
   output logic                 d_err,
   output logic [BUS_WIDTH-1:0] m_address,
   output logic [BUS_WIDTH-1:0] m_data_in,
   output logic                 m_wr_en,
   output logic [1:0]           m_mem_size,
   output logic                 m_sz_ex,
   input  logic [BUS_WIDTH-1:0] m_data_out
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t               r_state;
   logic                 r_sel_d;
   logic                 r_we;
   logic                 r_sz_ex;
   logic                 r_fault;
   logic [1:0]           r_size;
   logic [BUS_WIDTH-1:0] r_addr;
   logic [BUS_WIDTH-1:0] r_wdata;
   logic [BUS_WIDTH-1:0] r_if_rdata;
   logic [BUS_WIDTH-1:0] r_d_rdata;

   logic                 w_grant_d;
   logic [BUS_WIDTH-1:0] w_addr;
   logic [BUS_WIDTH-1:0] w_wdata;
   logic [1:0]           w_size;
   logic                 w_sz_ex;
   logic                 w_we;
   logic [BUS_WIDTH:0]   w_nbytes;
   logic [BUS_WIDTH:0]   w_last;
   logic                 w_fault;
   logic [BUS_WIDTH-1:0] w_rdata;

`ifdef MEM_ARB_RR_EN
   // Resets to "fetch served last", so the first contested grant goes to data.
   logic r_last_d;
   assign w_grant_d = d_req & (~if_req | ~r_last_d);
`else
   assign w_grant_d = d_req;
`endif

   assign w_addr  = w_grant_d ? d_addr  : if_addr;
   assign w_wdata = w_grant_d ? d_wdata : '0;
   assign w_size  = w_grant_d ? d_size  : 2'b10;
   assign w_sz_ex = w_grant_d & d_sz_ex;
   assign w_we    = w_grant_d & d_we;

   always_comb begin
      w_nbytes = (BUS_WIDTH+1)'(4);
      case (w_size)
         2'b00:   w_nbytes = (BUS_WIDTH+1)'(1);
         2'b01:   w_nbytes = (BUS_WIDTH+1)'(2);
         default: w_nbytes = (BUS_WIDTH+1)'(4);
      endcase
   end

   // One extra bit so an access wrapping past the top of the address space faults.
   assign w_last  = {1'b0, w_addr} + w_nbytes - (BUS_WIDTH+1)'(1);
   assign w_fault = (w_size == 2'b11)
                  | ((w_size == 2'b01) & w_addr[0])
                  | ((w_size == 2'b10) & (w_addr[1:0] != 2'b00))
                  | (w_last >= (BUS_WIDTH+1)'(MEM_DEPTH));

   assign w_rdata = (r_we | r_fault) ? '0 : m_data_out;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_sel_d    <= 1'b0;
         r_we       <= 1'b0;
         r_sz_ex    <= 1'b0;
         r_fault    <= 1'b0;
         r_size     <= 2'b00;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
`ifdef MEM_ARB_RR_EN
         r_last_d   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (if_req | d_req) begin
                  r_sel_d <= w_grant_d;
                  r_addr  <= w_addr;
                  r_wdata <= w_wdata;
                  r_size  <= w_size;
                  r_sz_ex <= w_sz_ex;
                  r_we    <= w_we;
                  r_fault <= w_fault;
                  r_state <= S_ACCESS;
`ifdef MEM_ARB_RR_EN
                  r_last_d <= w_grant_d;
`endif
               end
            end
            S_ACCESS: begin
               if (r_sel_d) r_d_rdata  <= w_rdata;
               else         r_if_rdata <= w_rdata;
               r_state <= S_RESP;
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign m_address  = r_addr;
   assign m_data_in  = r_wdata;
   assign m_mem_size = r_size;
   assign m_sz_ex    = r_sz_ex;
   assign m_wr_en    = (r_state == S_ACCESS) & r_we & ~r_fault;

   assign if_ack   = (r_state == S_RESP) & ~r_sel_d;
   assign d_ack    = (r_state == S_RESP) & r_sel_d;
   assign if_err   = if_ack & r_fault;
   assign d_err    = d_ack & r_fault;
   assign if_rdata = r_if_rdata;
   assign d_rdata  = r_d_rdata;

endmodule
`default_nettype wire
